// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide scheduler.
// Optional feature macro: MD_FAST_ZERO_EN (zero-operand multiply shortcut).
package md_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Magnitude of v when it is to be treated as signed.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/md_core.sv
// Iterative 64-bit datapath: shift-add multiply, restoring divide, one bit per step.
module md_core
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            div_q;
  logic [XLEN:0]   add_sum, shl, diff;

  // lo holds the multiplier (or dividend) and shifts out as the result shifts in.
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shl     = {hi_q, lo_q[XLEN-1]};
    diff    = shl - {1'b0, b_q};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      if (div_q) begin
        if (!diff[XLEN]) begin
          hi_q <= diff[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= shl[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi_q, lo_q} <= {add_sum, lo_q[XLEN-1:1]};
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler: FSM, iteration counter, sign fix-up and HI/LO write port.
// Build option MD_FAST_ZERO_EN: zero-operand mult/multu completes one cycle after start.
module md_sched
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stallreq,
  output logic            busy,
  output logic            hilo_we,
  output logic [XLEN-1:0] hi_wdata,
  output logic [XLEN-1:0] lo_wdata,
  output logic            div_zero
);

  state_e          state_q, state_nx;
  logic [CNT_W-1:0] cnt_q;
  logic            is_div_q, neg_res_q, neg_a_q, zero_q;
  logic            op_div, op_sgn, neg_a, neg_b, fast_zero, accept;
  logic [XLEN-1:0] a_abs, b_abs, core_hi, core_lo;
  hilo_t           fix_res, out_q;
  logic            hilo_we_q, busy_q, div_zero_q;

  always_comb begin
    op_div = (op == OP_DIV) || (op == OP_DIVU);
    op_sgn = (op == OP_MULT) || (op == OP_DIV);
    neg_a  = op_sgn & src_a[XLEN-1];
    neg_b  = op_sgn & src_b[XLEN-1];
    a_abs  = abs_val(src_a, op_sgn);
    b_abs  = abs_val(src_b, op_sgn);
    accept = (state_q == S_IDLE) & start & ~flush;
`ifdef MD_FAST_ZERO_EN
    fast_zero = ~op_div & ((src_a == '0) | (src_b == '0));
`else
    fast_zero = 1'b0;
`endif
  end

  assign stallreq = ((state_q == S_IDLE) & start) | (state_q == S_RUN) | (state_q == S_FIX);

  md_core u_core (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .step   (state_q == S_RUN),
    .is_div (op_div),
    .a      (a_abs),
    .b      (b_abs),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Next state; flush overrides everything, including a same-cycle start.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_nx = fast_zero ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == CNT_W'(ITER - 1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_nx;
  end

  // Operation context captured at start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      is_div_q  <= op_div;
      neg_res_q <= neg_a ^ neg_b;
      neg_a_q   <= neg_a;
      zero_q    <= (src_b == '0);
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient, remainder restores to src_a.
  always_comb begin
    fix_res = '0;
    if (is_div_q) begin
      fix_res.hi = neg_a_q ? XLEN'(-core_hi) : core_hi;
      fix_res.lo = zero_q ? '1 : (neg_res_q ? XLEN'(-core_lo) : core_lo);
    end else begin
      fix_res = neg_res_q ? hilo_t'(-{core_hi, core_lo}) : hilo_t'({core_hi, core_lo});
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hilo_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
      out_q      <= '0;
    end else begin
      hilo_we_q  <= (state_nx == S_DONE);
      busy_q     <= (state_nx != S_IDLE);
      div_zero_q <= 1'b0;
      if (state_nx == S_DONE) begin
        if (state_q == S_FIX) begin
          out_q      <= fix_res;
          div_zero_q <= is_div_q & zero_q;
        end else begin
          out_q <= '0;
        end
      end
    end
  end

  assign hilo_we  = hilo_we_q;
  assign busy     = busy_q;
  assign div_zero = div_zero_q;
  assign hi_wdata = out_q.hi;
  assign lo_wdata = out_q.lo;

endmodule

// File: tb/tb_md_sched.sv
// Randomized self-checking bench for md_sched against an arithmetic reference model.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        resetn, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy, hilo_we, div_zero;
  logic [31:0] hi_wdata, lo_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_sched dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stallreq (stallreq),
    .busy     (busy),
    .hilo_we  (hilo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'd0: begin q = sa * sb; return {1'b0, 64'(q)}; end
      2'd1: return {1'b0, ua * ub};
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_FAST_ZERO_EN
    if (!o[1] && (a == 0 || b == 0)) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 15));
      4: return 32'(-$urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation; poke >= 0 pulses a spurious start at that cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [64:0] e;
    int n, stall_bad;
    e = model(o, a, b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check("stall_c0", 64'(stallreq), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    #1;
    n = 1;
    stall_bad = 0;
    check("busy_c1", 64'(busy), 64'd1);
    while (!hilo_we && n < 40) begin
      if (!stallreq) stall_bad++;
      if (n == poke) begin
        start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat(o, a, b)));
    check("stall_run", 64'(stall_bad), 64'd0);
    check("stall_done", 64'(stallreq), 64'd0);
    check("hilo", {hi_wdata, lo_wdata}, e[63:0]);
    check("div_zero", 64'(div_zero), 64'(e[64]));
    @(posedge clk); #2;
    check("we_pulse", 64'(hilo_we), 64'd0);
    check("hold", {hi_wdata, lo_wdata}, e[63:0]);
    check("idle", 64'(busy), 64'd0);
  endtask

  task automatic count_we(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #2;
      if (hilo_we) seen++;
    end
  endtask

  initial begin
    int seen;
    resetn = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    #2 resetn = 1'b0;
    #1;
    check("rst_out", {32'(hilo_we), 32'(busy)}, 64'd0);
    check("rst_data", {hi_wdata, lo_wdata}, 64'd0);
    #20 resetn = 1'b1;
    @(posedge clk); #2;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(2'd0, 32'(-3), 32'd5, -1);
    run_op(2'd2, 32'(-7), 32'd2, -1);
    run_op(2'd3, 32'd7, 32'd0, -1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, -1);
    run_op(2'd0, 32'd0, 32'h1234, -1);

    // Flush at cycle 10 of a divide, then an immediate new start.
    start = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_we", 64'(hilo_we), 64'd0);
    run_op(2'd3, 32'd100, 32'd7, -1);

    // flush and start together in IDLE: nothing starts.
    start = 1'b1; flush = 1'b1; op = 2'd1; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start_busy", 64'(busy), 64'd0);
    count_we(40, seen);
    check("flush_start_we", 64'(seen), 64'd0);

    // Asynchronous reset mid-operation.
    start = 1'b1; op = 2'd0; src_a = 32'd12345; src_b = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    check("arst_ctl", {32'(hilo_we), 16'(busy), 8'(stallreq), 8'(div_zero)}, 64'd0);
    check("arst_data", {hi_wdata, lo_wdata}, 64'd0);
    @(posedge clk); @(posedge clk); #3;
    resetn = 1'b1;
    count_we(40, seen);
    check("arst_we", 64'(seen), 64'd0);
    run_op(2'd1, 32'd9, 32'd11, -1);

    // Spurious start while running is ignored.
    run_op(2'd0, 32'(-3), 32'd5, 5);
    count_we(40, seen);
    check("poke_single", 64'(seen), 64'd0);

    repeat (24) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
